alu_issue_sequencer: RTL and testbench

- Sequences one decoded instruction at a time through the shared ALU.
- Accepts the 5-bit ALU control code and operands from decode over a valid/ready handshake.
- Issues the operation to the ALU and waits for completion when the operation is multi-cycle.
- Presents the result to register-file writeback over a valid/ready handshake. It also guards against a hung ALU with a watchdog and rejects illegal control codes.

---
 rtl/alu_pkg.sv | 17 +
 rtl/seq_watchdog.sv | 32 +++
 rtl/alu_issue_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_issue_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: code width, legal-code limit,
// multi-cycle mask default and the sequencer state encoding.
package alu_pkg;

  localparam int                    ALU_CODE_W   = 5;
  localparam int                    DATA_W_DEF   = 32;
  localparam logic [ALU_CODE_W-1:0] MAX_CODE_DEF = 5'd29;
  localparam logic [31:0]           MC_MASK_DEF  = 32'h0000_007C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter that bounds how long the sequencer waits on a multi-cycle ALU op.
// expire is high during the last permitted cycle of waiting.
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issues one decoded instruction at a time to the shared ALU, waits for
// multi-cycle completion under a watchdog, and hands the result to writeback.
module alu_issue_sequencer
  import alu_pkg::*;
#(
  parameter int                    DATA_W   = DATA_W_DEF,
  parameter int                    TIMEOUT  = 64,
  parameter logic [31:0]           MC_MASK  = MC_MASK_DEF,
  parameter logic [ALU_CODE_W-1:0] MAX_CODE = MAX_CODE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CODE_W-1:0] in_alu_ctrl,
  input  logic [4:0]            in_rd,
  input  logic [DATA_W-1:0]     in_op_a,
  input  logic [DATA_W-1:0]     in_op_b,
  output logic                  alu_start,
  output logic [ALU_CODE_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_done,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  busy,
  output logic                  illegal_op,
  output logic                  timeout_err
);

  seq_state_e state, state_next;

  logic [ALU_CODE_W-1:0] cap_ctrl;
  logic [4:0]            cap_rd;
  logic [DATA_W-1:0]     cap_a;
  logic [DATA_W-1:0]     cap_b;
  logic [DATA_W-1:0]     wb_data_q;
  logic                  illegal_q;
  logic                  timeout_q;

  logic accept;
  logic is_mc;
  logic wd_expire;
  logic result_load;
  logic timeout_hit;

  assign accept      = in_valid && (state == IDLE);
  assign is_mc       = MC_MASK[cap_ctrl];
  assign result_load = ((state == EXEC) && !is_mc) || ((state == WAIT) && alu_done);
  // A completion in the final watchdog cycle still counts as success.
  assign timeout_hit = (state == WAIT) && !alu_done && wd_expire;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == EXEC),
    .enable (state == WAIT),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_ctrl  <= '0;
      cap_rd    <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      illegal_q <= 1'b0;
      if (accept) begin
        cap_ctrl  <= in_alu_ctrl;
        cap_rd    <= in_rd;
        cap_a     <= in_op_a;
        cap_b     <= in_op_b;
        illegal_q <= (in_alu_ctrl > MAX_CODE);
      end
      if (result_load) wb_data_q <= alu_result;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept && !(in_alu_ctrl > MAX_CODE)) state_next = EXEC;
      EXEC: begin
        if (is_mc)              state_next = WAIT;
        else if (cap_rd != '0)  state_next = WB;
        else                    state_next = IDLE;
      end
      WAIT: begin
        if (alu_done)           state_next = (cap_rd != '0) ? WB : IDLE;
        else if (wd_expire)     state_next = IDLE;
      end
      WB:   if (wb_ready) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    alu_start = (state == EXEC);
    alu_ctrl  = '0;
    alu_a     = '0;
    alu_b     = '0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    if (state == EXEC || state == WAIT) begin
      alu_ctrl = cap_ctrl;
      alu_a    = cap_a;
      alu_b    = cap_b;
    end
    if (state == WB) begin
      wb_valid = 1'b1;
      wb_rd    = cap_rd;
      wb_data  = wb_data_q;
    end
  end

  assign illegal_op  = illegal_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer: table of single-cycle ops plus
// directed multi-cycle, backpressure, x0, illegal, watchdog and reset sequences.
module tb_alu_issue_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_alu_ctrl;
  logic [4:0]  in_rd;
  logic [31:0] in_op_a;
  logic [31:0] in_op_b;
  logic        alu_start;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_done;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic        illegal_op;
  logic        timeout_err;

  logic        mc_override;
  logic [31:0] mc_value;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;
  wb_exp_t sb_q[$];

  typedef struct {
    logic [4:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  alu_issue_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_ctrl (in_alu_ctrl),
    .in_rd       (in_rd),
    .in_op_a     (in_op_a),
    .in_op_b     (in_op_b),
    .alu_start   (alu_start),
    .alu_ctrl    (alu_ctrl),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_done    (alu_done),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .busy        (busy),
    .illegal_op  (illegal_op),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [4:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd7:    return a & b;
      5'd8:    return a | b;
      5'd9:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign alu_result = mc_override ? mc_value : alu_fn(alu_ctrl, alu_a, alu_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle after acceptance (the EXEC cycle for legal codes).
  task automatic send(input logic [4:0] c, input logic [4:0] rd, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input bit expect_wb);
    int n = 0;
    in_valid    = 1'b1;
    in_alu_ctrl = c;
    in_rd       = rd;
    in_op_a     = a;
    in_op_b     = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    if (expect_wb && c <= MAX_CODE_DEF && rd != 5'd0) sb_q.push_back('{rd: rd, data: exp});
    tick();
    in_valid = 1'b0;
  endtask

  // Writeback monitor: compares each completed handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", {59'd0, wb_rd}, 64'd0);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        check("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
        check("wb_data", {32'd0, wb_data}, {32'd0, e.data});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{ctrl: 5'd0,  rd: 5'd5,  a: 32'd7,         b: 32'd3,         exp: 32'd10};
    vecs[1] = '{ctrl: 5'd1,  rd: 5'd6,  a: 32'd20,        b: 32'd5,         exp: 32'd15};
    vecs[2] = '{ctrl: 5'd7,  rd: 5'd8,  a: 32'hF0F0_1234, b: 32'h0FF0_FFFF, exp: 32'h00F0_1234};
    vecs[3] = '{ctrl: 5'd8,  rd: 5'd10, a: 32'h0000_00F0, b: 32'h0000_000F, exp: 32'h0000_00FF};
    vecs[4] = '{ctrl: 5'd9,  rd: 5'd31, a: 32'hFFFF_0000, b: 32'h0F0F_0F0F, exp: 32'hF0F0_0F0F};
    vecs[5] = '{ctrl: 5'd1,  rd: 5'd1,  a: 32'd0,         b: 32'd1,         exp: 32'hFFFF_FFFF};
    vecs[6] = '{ctrl: 5'd29, rd: 5'd2,  a: 32'h10,        b: 32'h20,        exp: 32'h30};

    rst_n = 1'b0; in_valid = 1'b0; in_alu_ctrl = '0; in_rd = '0; in_op_a = '0; in_op_b = '0;
    alu_done = 1'b0; wb_ready = 1'b1; mc_override = 1'b0; mc_value = '0;
    tick(); tick();
    rst_n = 1'b1;

    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_alu_ops", {alu_ctrl, alu_a, alu_b} == '0, 1);
    check("rst_wb", {wb_valid, wb_rd, wb_data} == '0, 1);
    check("rst_flags", {illegal_op, timeout_err}, 0);

    // Single-cycle table: start 1 cycle after accept, wb 2 cycles, ready at 3.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].ctrl, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].exp, 1);
      check("sc_alu_start", alu_start, 1);
      check("sc_in_ready_exec", in_ready, 0);
      tick();
      check("sc_wb_valid", wb_valid, 1);
      check("sc_alu_start_off", alu_start, 0);
      tick();
      check("sc_in_ready_back", in_ready, 1);
    end

    // Multi-cycle: done 5 cycles after start, wb at cycle 7.
    send(5'd4, 5'd9, 32'hAAAA_0001, 32'h5555_0002, 32'h1234, 1);
    check("mc_alu_start", alu_start, 1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      check("mc_start_low", alu_start, 0);
      check("mc_ops_stable", {alu_ctrl, alu_a, alu_b}, {5'd4, 32'hAAAA_0001, 32'h5555_0002});
      check("mc_wait_no_wb", wb_valid, 0);
    end
    alu_done = 1'b1; mc_override = 1'b1; mc_value = 32'h1234;
    tick();
    alu_done = 1'b0; mc_override = 1'b0;
    check("mc_wb_valid", wb_valid, 1);
    check("mc_ops_zero_wb", {alu_ctrl, alu_a, alu_b} == '0, 1);
    tick();

    // Writeback backpressure with a competing instruction on the input.
    wb_ready = 1'b0;
    send(5'd1, 5'd3, 32'd100, 32'd1, 32'd99, 1);
    tick();
    in_valid = 1'b1; in_alu_ctrl = 5'd0; in_rd = 5'd20; in_op_a = 32'd1; in_op_b = 32'd1;
    for (int c = 0; c < 4; c++) begin
      check("bp_wb_hold", {wb_valid, wb_rd, wb_data}, {1'b1, 5'd3, 32'd99});
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    tick();
    check("bp_released", {in_ready, wb_valid}, 2'b10);

    // x0 destination: executes but never writes back.
    send(5'd0, 5'd0, 32'd1, 32'd2, 32'd3, 1);
    check("x0_alu_start", alu_start, 1);
    tick();
    check("x0_no_wb", {wb_valid, busy, in_ready}, 3'b001);

    // Illegal code: single illegal_op pulse, no issue.
    send(5'd30, 5'd4, 32'd1, 32'd2, 32'd0, 1);
    check("ill_pulse", {illegal_op, alu_start, in_ready}, 3'b101);
    tick();
    check("ill_pulse_end", {illegal_op, alu_start, busy}, 3'b000);

    // Watchdog expiry: error 64 cycles after entering WAIT, sticky.
    send(5'd2, 5'd4, 32'd5, 32'd6, 32'd0, 0);
    repeat (64) tick();
    check("wd_before", {timeout_err, busy}, 2'b01);
    tick();
    check("wd_expired", {timeout_err, busy, wb_valid}, 3'b100);
    send(vecs[0].ctrl, vecs[0].rd, vecs[0].a, vecs[0].b, vecs[0].exp, 1);
    tick();
    check("wd_next_wb", wb_valid, 1);
    check("wd_sticky", timeout_err, 1);
    tick();

    // Reset mid-WAIT abandons the op and clears the sticky error.
    send(5'd5, 5'd7, 32'd1, 32'd1, 32'd0, 0);
    tick();
    check("rw_in_wait", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rw_after_reset", {busy, in_ready, timeout_err, wb_valid}, 4'b0100);
    alu_done = 1'b1; mc_override = 1'b1; mc_value = 32'hDEAD;
    tick();
    alu_done = 1'b0; mc_override = 1'b0;
    check("rw_late_done", {wb_valid, busy}, 2'b00);

    // Done coincides with the last watchdog count: result wins, no error.
    send(5'd3, 5'd12, 32'd8, 32'd9, 32'hCAFE_0003, 1);
    repeat (64) tick();
    alu_done = 1'b1; mc_override = 1'b1; mc_value = 32'hCAFE_0003;
    tick();
    alu_done = 1'b0; mc_override = 1'b0;
    check("wd_edge_wb", {wb_valid, wb_rd, timeout_err}, {1'b1, 5'd12, 1'b0});
    tick();
    tick();
    check("wd_edge_no_err", timeout_err, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
